// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
//
// Purpose:
//   Sequences trap entry and return around the exception checker. Owns the
//   machine CSRs (mstatus, mie, mtvec, mepc, mcause). On a trap it captures
//   the checker's result, stalls the core for FLUSH_CYC cycles, redirects the
//   PC to mtvec, and waits in HANDLER for uret. It then redirects to the
//   return address and re-arms the checker.
//
// Parameters:
//   MTVEC_RST   handler address loaded into mtvec at reset
//   FLUSH_CYC   stall cycles spent in FLUSH before the vector redirect (1..15)
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   exception    checker: trap detected this cycle
//   excep_info   checker: {type[31], cause[30:24], mstatus[23:16], mret[15:0]}
//   uret         decoded uret in execute (one-cycle pulse)
//   csr_we       CSR write strobe (csrrw/csrrwi)
//   csr_addr     CSR address (300 mstatus, 304 mie, 305 mtvec, 341 mepc, 342 mcause)
//   csr_wdata    CSR write data
//   csr_rdata    CSR read data, combinational on csr_addr, 0 when unmapped
//   csr_info     to checker: {15'b0, mie, 8'h00, mstatus}
//   stall        freeze PC and write-backs
//   pc_redirect  load pc_target into the PC this cycle
//   pc_target    redirect address
//   in_trap      high from trap capture until the return redirect completes
// -----------------------------------------------------------------------------
module trap_sequencer #(
    parameter logic [15:0] MTVEC_RST = 16'h0100,
    parameter int          FLUSH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exception,
    input  logic [31:0] excep_info,
    input  logic        uret,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic [31:0] csr_info,
    output logic        stall,
    output logic        pc_redirect,
    output logic [15:0] pc_target,
    output logic        in_trap
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FLUSH   = 3'd1;
    localparam logic [2:0] VECTOR  = 3'd2;
    localparam logic [2:0] HANDLER = 3'd3;
    localparam logic [2:0] RETURN  = 3'd4;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    // mstatus values: 8'h01 arms the checker, 8'h10 marks "inside a trap".
    localparam logic [7:0] MSTATUS_ARMED    = 8'h01;
    localparam logic [7:0] MSTATUS_DISARMED = 8'h10;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYC - 1);

    logic [2:0]  state, state_next;
    logic [3:0]  cnt;
    logic [7:0]  mstatus;
    logic        mie;
    logic [15:0] mtvec;
    logic [15:0] mepc;
    logic [31:0] mcause;

    logic        take_trap;
    logic        csr_wr_en;
    logic [15:0] ret_target;

    // A trap is only accepted in IDLE; in every other state the checker is
    // disarmed and the exception input is deliberately ignored.
    assign take_trap = (state == IDLE) && exception;

    // Software CSR writes land only while the core is running normally. A
    // write coinciding with a trap is dropped so the trap capture wins.
    assign csr_wr_en = csr_we && (((state == IDLE) && !exception) || (state == HANDLER));

    // Exceptions resume after the faulting instruction; interrupts re-execute
    // the interrupted one. The 16-bit add wraps naturally.
    assign ret_target = mcause[31] ? mepc : (mepc + 16'd4);

    // NOTE: every signal driven from always_comb gets a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (exception) state_next = FLUSH;
            FLUSH:   if (cnt == 4'd0) state_next = VECTOR;
            VECTOR:  state_next = HANDLER;
            HANDLER: if (uret) state_next = RETURN;
            RETURN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            mstatus <= MSTATUS_ARMED;
            mie     <= 1'b0;
            mtvec   <= MTVEC_RST;
            mepc    <= 16'd0;
            mcause  <= 32'd0;
        end else begin
            state <= state_next;

            if (state == FLUSH && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (take_trap) begin
                mepc    <= excep_info[15:0];
                mcause  <= {excep_info[31], 24'd0, excep_info[30:24]};
                mstatus <= MSTATUS_DISARMED;
                cnt     <= CNT_INIT;
            end else if (state == RETURN) begin
                // Re-arm unconditionally, overriding anything the handler wrote.
                mstatus <= MSTATUS_ARMED;
            end else if (csr_wr_en) begin
                case (csr_addr)
                    ADDR_MSTATUS: mstatus <= csr_wdata[7:0];
                    ADDR_MIE:     mie     <= csr_wdata[0];
                    ADDR_MTVEC:   mtvec   <= csr_wdata[15:0];
                    ADDR_MEPC:    mepc    <= csr_wdata[15:0];
                    ADDR_MCAUSE:  mcause  <= csr_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            ADDR_MSTATUS: csr_rdata = {24'd0, mstatus};
            ADDR_MIE:     csr_rdata = {31'd0, mie};
            ADDR_MTVEC:   csr_rdata = {16'd0, mtvec};
            ADDR_MEPC:    csr_rdata = {16'd0, mepc};
            ADDR_MCAUSE:  csr_rdata = mcause;
            default:      csr_rdata = 32'd0;
        endcase
    end

    always_comb begin
        pc_target = 16'd0;
        case (state)
            VECTOR:  pc_target = mtvec;
            RETURN:  pc_target = ret_target;
            default: pc_target = 16'd0;
        endcase
    end

    assign csr_info    = {15'd0, mie, 8'h00, mstatus};
    assign pc_redirect = (state == VECTOR) || (state == RETURN);
    // Stall goes high combinationally in the capture cycle so nothing
    // behind the trapping instruction retires.
    assign stall       = take_trap || (state == FLUSH) || (state == VECTOR) || (state == RETURN);
    assign in_trap     = (state != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trap_sequencer
//
// Purpose:
//   Self-checking bench for trap_sequencer. CSR read/write behaviour is
//   exercised from a table of vectors; trap entry/return sequences are
//   hand-written, with every expected redirect target pushed to a queue when
//   the stimulus is driven and popped when the DUT asserts pc_redirect.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exception;
    logic [31:0] excep_info;
    logic        uret;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] csr_info;
    logic        stall;
    logic        pc_redirect;
    logic [15:0] pc_target;
    logic        in_trap;

    int n_checks = 0;
    int n_passed = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } csr_vec_t;

    trap_sequencer #(.MTVEC_RST(16'h0100), .FLUSH_CYC(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exception   (exception),
        .excep_info  (excep_info),
        .uret        (uret),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_info    (csr_info),
        .stall       (stall),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .in_trap     (in_trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_passed++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    endtask

    // Advance to just after the next rising edge; outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_csr(input string name, input logic [11:0] addr, input logic [31:0] expected);
        csr_addr = addr;
        #1;
        check(name, csr_rdata, expected);
    endtask

    // Pop the oldest expected redirect target and compare with pc_target.
    task automatic pop_redirect(input string name);
        logic [15:0] exp_t;
        if (exp_q.size() == 0) begin
            check({name, " unexpected redirect"}, 32'd1, 32'd0);
        end else begin
            exp_t = exp_q.pop_front();
            check({name, " target"}, {16'd0, pc_target}, {16'd0, exp_t});
        end
    endtask

    // Drive an exception from IDLE, then follow the sequence to the vector
    // redirect, which must arrive in cycle 3 (FLUSH_CYC=2) with stall high
    // in every cycle before it.
    task automatic enter_trap(input string name, input logic [31:0] info, input logic [15:0] vec,
                              input logic we, input logic [31:0] wdata);
        bit seen;
        seen       = 1'b0;
        exception  = 1'b1;
        excep_info = info;
        csr_we     = we;
        csr_addr   = 12'h305;
        csr_wdata  = wdata;
        exp_q.push_back(vec);
        #1;
        check({name, " stall c0"}, {31'd0, stall}, 32'd1);
        check({name, " redirect c0"}, {31'd0, pc_redirect}, 32'd0);
        for (int n = 1; n <= 20 && !seen; n++) begin
            tick();
            exception = 1'b0;
            csr_we    = 1'b0;
            #1;
            if (pc_redirect) begin
                seen = 1'b1;
                check({name, " vector cycle"}, n, 3);
                check({name, " stall vec"}, {31'd0, stall}, 32'd1);
                pop_redirect({name, " vector"});
            end else begin
                check($sformatf("%s stall c%0d", name, n), {31'd0, stall}, 32'd1);
            end
        end
        if (!seen) check({name, " vector timeout"}, 32'd0, 32'd1);
        tick();
        check({name, " handler stall"}, {31'd0, stall}, 32'd0);
        check({name, " handler in_trap"}, {31'd0, in_trap}, 32'd1);
    endtask

    // From HANDLER: pulse uret, expect the return redirect next cycle, then
    // IDLE with mstatus re-armed.
    task automatic leave_trap(input string name, input logic [15:0] ret);
        uret = 1'b1;
        exp_q.push_back(ret);
        tick();
        uret = 1'b0;
        #1;
        check({name, " ret redirect"}, {31'd0, pc_redirect}, 32'd1);
        check({name, " ret stall"}, {31'd0, stall}, 32'd1);
        if (pc_redirect) pop_redirect({name, " return"});
        tick();
        check({name, " in_trap after"}, {31'd0, in_trap}, 32'd0);
        check({name, " redirect after"}, {31'd0, pc_redirect}, 32'd0);
        read_csr({name, " mstatus after"}, 12'h300, 32'h0000_0001);
    endtask

    csr_vec_t vecs[8];

    initial begin
        rst_n      = 1'b0;
        exception  = 1'b0;
        excep_info = 32'd0;
        uret       = 1'b0;
        csr_we     = 1'b0;
        csr_addr   = 12'h305;
        csr_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state, observed while still held in reset and after release.
        check("reset csr_info", csr_info, 32'h0000_0001);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset pc_redirect", {31'd0, pc_redirect}, 32'd0);
        check("reset pc_target", {16'd0, pc_target}, 32'd0);
        check("reset in_trap", {31'd0, in_trap}, 32'd0);
        rst_n = 1'b1;
        tick();
        read_csr("reset mtvec", 12'h305, 32'h0000_0100);
        read_csr("reset mepc", 12'h341, 32'h0000_0000);
        read_csr("reset mcause", 12'h342, 32'h0000_0000);

        // Table-driven CSR writes: each write is followed by a read of the
        // same address on the next cycle.
        vecs[0] = '{1'b1, 12'h304, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[1] = '{1'b1, 12'h300, 32'h1234_56AB, 32'h0000_00AB};
        vecs[2] = '{1'b1, 12'h341, 32'hDEAD_BEEF, 32'h0000_BEEF};
        vecs[3] = '{1'b1, 12'h342, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 12'h123, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{1'b1, 12'h305, 32'h0000_0100, 32'h0000_0100};
        vecs[6] = '{1'b1, 12'h304, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{1'b1, 12'h300, 32'h0000_0001, 32'h0000_0001};
        for (int i = 0; i < 8; i++) begin
            csr_we    = vecs[i].we;
            csr_addr  = vecs[i].addr;
            csr_wdata = vecs[i].wdata;
            tick();
            csr_we = 1'b0;
            #1;
            check($sformatf("csr vec %0d", i), csr_rdata, vecs[i].exp_rdata);
            if (i == 0) check("csr_info mie", csr_info, 32'h0001_00AB & 32'h0001_0001 | 32'h0000_0001);
        end
        check("csr_info idle", csr_info, 32'h0000_0001);

        // uret outside HANDLER is ignored.
        uret = 1'b1;
        tick();
        uret = 1'b0;
        #1;
        check("idle uret redirect", {31'd0, pc_redirect}, 32'd0);
        check("idle uret in_trap", {31'd0, in_trap}, 32'd0);

        // Exception entry and return.
        enter_trap("exc", 32'h0210_0040, 16'h0100, 1'b0, 32'd0);
        read_csr("exc mepc", 12'h341, 32'h0000_0040);
        read_csr("exc mcause", 12'h342, 32'h0000_0002);
        read_csr("exc mstatus", 12'h300, 32'h0000_0010);
        check("exc csr_info", csr_info, 32'h0000_0010);
        // Handler writes mstatus; return must still re-arm to 8'h01.
        csr_we = 1'b1; csr_addr = 12'h300; csr_wdata = 32'h0000_00FF;
        tick();
        csr_we = 1'b0;
        read_csr("handler mstatus write", 12'h300, 32'h0000_00FF);
        leave_trap("exc", 16'h0044);

        // Interrupt: return to mepc itself.
        enter_trap("irq", 32'h9010_0080, 16'h0100, 1'b0, 32'd0);
        csr_addr = 12'h342;
        #1;
        check("irq mcause type", {24'd0, csr_rdata[31:24]}, 32'h0000_0080);
        leave_trap("irq", 16'h0080);

        // CSR write in the trap cycle is dropped; a handler write sticks.
        enter_trap("drop", 32'h0310_0100, 16'h0100, 1'b1, 32'h0000_0200);
        read_csr("drop mtvec", 12'h305, 32'h0000_0100);
        csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h0000_0200;
        tick();
        csr_we = 1'b0;
        read_csr("handler mtvec", 12'h305, 32'h0000_0200);
        leave_trap("drop", 16'h0104);
        enter_trap("newvec", 32'h0210_0300, 16'h0200, 1'b0, 32'd0);
        // Exception input is ignored while already in a trap.
        exception = 1'b1; excep_info = 32'h0510_7777;
        tick();
        exception = 1'b0;
        check("nested in_trap", {31'd0, in_trap}, 32'd1);
        read_csr("nested mepc", 12'h341, 32'h0000_0300);
        leave_trap("newvec", 16'h0304);

        // Reset during FLUSH: no redirect, back to IDLE values.
        exception = 1'b1; excep_info = 32'h0210_0500;
        tick();
        exception = 1'b0;
        #1;
        check("rst flush in_trap", {31'd0, in_trap}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst in_trap", {31'd0, in_trap}, 32'd0);
        check("rst stall", {31'd0, stall}, 32'd0);
        for (int n = 0; n < 4; n++) begin
            tick();
            check($sformatf("rst redirect c%0d", n), {31'd0, pc_redirect}, 32'd0);
        end
        rst_n = 1'b1;
        tick();
        read_csr("rst mstatus", 12'h300, 32'h0000_0001);
        read_csr("rst mtvec", 12'h305, 32'h0000_0100);
        for (int n = 0; n < 4; n++) begin
            tick();
            check($sformatf("post rst redirect c%0d", n), {31'd0, pc_redirect}, 32'd0);
        end

        // Return-address wrap: 16'hFFFC + 4 -> 16'h0000.
        enter_trap("wrap", 32'h0110_FFFC, 16'h0100, 1'b0, 32'd0);
        leave_trap("wrap", 16'h0000);

        check("scoreboard empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
